// File: rtl/llama_layer_fix_pkg.sv
// Fixed-point types and constants shared by the llama layer product/requant datapath.
// The multiplier's neighbours reuse prod_t/act_t so widths stay consistent across blocks.
package llama_layer_fix_pkg;

    localparam int IN_W_DEF    = 80;
    localparam int OUT_W_DEF   = 32;
    localparam int SHIFT_W_DEF = 7;
    localparam int CNT_W_DEF   = 16;

    typedef logic signed [IN_W_DEF-1:0]  prod_t;
    typedef logic signed [OUT_W_DEF-1:0] act_t;

    localparam act_t OUT_MAX = 32'sh7FFF_FFFF;
    localparam act_t OUT_MIN = 32'sh8000_0000;

endpackage

// File: rtl/llama_layer_sat_clip.sv
// Combinational signed clip of a wide (IN_W+1)-bit value into OUT_W bits, flagging clipping.
module llama_layer_sat_clip
    import llama_layer_fix_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic signed [IN_W:0]    in_val,
    output logic        [OUT_W-1:0] out_val,
    output logic                    sat
);

    localparam logic [OUT_W-1:0] CLIP_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] CLIP_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // The value fits iff every bit from the OUT_W sign position upward matches.
    logic [IN_W-OUT_W+1:0] hi_bits;
    logic                  fits;

    assign hi_bits = in_val[IN_W:OUT_W-1];
    assign fits    = (&hi_bits) | (~|hi_bits);

    always_comb begin
        sat     = !fits;
        out_val = in_val[OUT_W-1:0];
        if (!fits) begin
            out_val = in_val[IN_W] ? CLIP_MIN : CLIP_MAX;
        end
    end

endmodule

// File: rtl/llama_layer_requant_80_32.sv
// Requantizes the 80-bit signed product to a 32-bit activation: rounding arithmetic right shift,
// then saturation, in a two-deep valid/ready pipeline with a sticky saturation event counter.
module llama_layer_requant_80_32
    import llama_layer_fix_pkg::*;
#(
    parameter int IN_W    = IN_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT_W = SHIFT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [IN_W-1:0]    in_data,
    input  logic        [SHIFT_W-1:0] in_shift,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [OUT_W-1:0]   out_data,
    output logic                      out_sat,
    output logic        [CNT_W-1:0]   sat_count,
    input  logic                      clear_cnt
);

    localparam logic [SHIFT_W-1:0] S_MAX   = SHIFT_W'(IN_W - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    logic                      v1_q, v1_d;
    logic                      v2_q, v2_d;
    logic signed [IN_W:0]      s1_val_q, s1_val_d;
    logic        [OUT_W-1:0]   out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;
    logic        [CNT_W-1:0]   sat_count_q, sat_count_d;

    logic                      adv1, adv2, accept, load2, out_fire;
    logic        [SHIFT_W-1:0] shift_c;
    logic signed [IN_W:0]      ext, rnd, sum, rounded;
    logic        [OUT_W-1:0]   clip_val;
    logic                      clip_sat;

    // One extra bit of headroom keeps the half-LSB rounding add from overflowing.
    always_comb begin
        shift_c = (in_shift > S_MAX) ? S_MAX : in_shift;
        ext     = {in_data[IN_W-1], in_data};
        rnd     = '0;
        if (shift_c != '0) begin
            rnd = (IN_W+1)'(1) << (shift_c - SHIFT_W'(1));
        end
        sum     = ext + rnd;
        rounded = sum >>> shift_c;
    end

    llama_layer_sat_clip #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_sat_clip (
        .in_val  (s1_val_q),
        .out_val (clip_val),
        .sat     (clip_sat)
    );

    always_comb begin
        adv2     = !v2_q || out_ready;
        adv1     = !v1_q || adv2;
        in_ready = ap_rst_n && adv1;
        accept   = in_valid && in_ready;
        load2    = adv2 && v1_q;
        out_fire = v2_q && out_ready;

        v1_d       = adv1 ? accept : v1_q;
        s1_val_d   = accept ? rounded : s1_val_q;
        v2_d       = adv2 ? v1_q : v2_q;
        out_data_d = load2 ? clip_val : out_data_q;
        out_sat_d  = load2 ? clip_sat : out_sat_q;

        // Clear beats a coincident increment; the counter saturates instead of wrapping.
        sat_count_d = sat_count_q;
        if (clear_cnt) begin
            sat_count_d = '0;
        end else if (out_fire && out_sat_q && (sat_count_q != CNT_MAX)) begin
            sat_count_d = sat_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            s1_val_q    <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            s1_val_q    <= s1_val_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = v2_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_llama_layer_requant_80_32.sv
// Scoreboard bench for the 80->32 requantizer: directed vectors push expected beats, a monitor
// pops and compares on every output handshake and checks output hold during back-pressure.
module tb_llama_layer_requant_80_32;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [79:0] in_data = '0;
    logic        [6:0]  in_shift = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic        [31:0] out_data;
    logic               out_sat;
    logic        [15:0] sat_count;
    logic               clear_cnt = 1'b0;

    typedef struct {
        logic [31:0] d;
        logic        s;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic signed [79:0] P40  = 80'sh100_0000_0000;
    localparam logic signed [79:0] PMAX = {1'b0, {79{1'b1}}};
    localparam logic signed [79:0] PMIN = {1'b1, {79{1'b0}}};

    llama_layer_requant_80_32 dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_count (sat_count),
        .clear_cnt (clear_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge with in_valid low.
    task automatic send(input logic signed [79:0] d, input logic [6:0] s,
                        input logic [31:0] ed, input logic es);
        int n;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_shift = s;
        n = 0;
        forever begin
            @(negedge ap_clk);
            if (in_ready) begin
                e.d = ed;
                e.s = es;
                sb.push_back(e);
                @(posedge ap_clk);
                #1;
                break;
            end
            n++;
            if (n > 200) begin
                chk("send_timeout", 32'(n), 32'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_cnt(input string name, input logic [15:0] exp);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge ap_clk);
            n++;
        end
        chk({name, "_drain"}, 32'(sb.size()), 32'd0);
        @(negedge ap_clk);
        chk(name, 32'(sat_count), 32'(exp));
        @(posedge ap_clk);
        #1;
    endtask

    // Monitor: compare each delivered beat, and require stability while stalled.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_sat;
        exp_t        e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_sat   = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (prev_stall) begin
                vectors++;
                if (!out_valid || out_data !== prev_data || out_sat !== prev_sat) begin
                    miscompares++;
                    $display("FAIL hold: got v=%b d=%h s=%b expected v=1 d=%h s=%b",
                             out_valid, out_data, out_sat, prev_data, prev_sat);
                end
            end
            prev_stall = out_valid && !out_ready && ap_rst_n;
            prev_data  = out_data;
            prev_sat   = out_sat;
            if (out_valid && out_ready && ap_rst_n) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: got d=%h s=%b expected no beat", out_data, out_sat);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_sat !== e.s) begin
                        miscompares++;
                        $display("FAIL beat: got d=%h s=%b expected d=%h s=%b",
                                 out_data, out_sat, e.d, e.s);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_sat_count", 32'(sat_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge ap_clk);
        #1;
        ap_rst_n  = 1'b1;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;

        // Rounding plus exact two-cycle latency.
        send(80'sd98304, 7'd16, 32'd2, 1'b0);
        @(negedge ap_clk);
        chk("lat_early", 32'(out_valid), 32'd0);
        @(posedge ap_clk);
        @(negedge ap_clk);
        chk("lat_2", 32'(out_valid), 32'd1);
        @(posedge ap_clk);
        #1;
        send(-80'sd98304,  7'd16, 32'hFFFF_FFFF, 1'b0);
        send(-80'sd163840, 7'd16, 32'hFFFF_FFFE, 1'b0);

        // Saturation and the 2^31 boundary.
        send(P40, 7'd0, 32'h7FFF_FFFF, 1'b1);
        check_cnt("cnt_1", 16'd1);
        send(-P40, 7'd0, 32'h8000_0000, 1'b1);
        check_cnt("cnt_2", 16'd2);
        send(P40, 7'd9,  32'h7FFF_FFFF, 1'b1);
        send(P40, 7'd10, 32'h4000_0000, 1'b0);
        check_cnt("cnt_3", 16'd3);
        send(80'sh7FFF_FFFF,   7'd0, 32'h7FFF_FFFF, 1'b0);
        send(80'sh8000_0000,   7'd0, 32'h7FFF_FFFF, 1'b1);
        send(-80'sh8000_0000,  7'd0, 32'h8000_0000, 1'b0);
        send(-80'sh8000_0001,  7'd0, 32'h8000_0000, 1'b1);
        // Shift amounts past the input width clamp to 79.
        send(PMAX, 7'd100, 32'h0000_0001, 1'b0);
        send(PMIN, 7'd127, 32'hFFFF_FFFF, 1'b0);
        check_cnt("cnt_5", 16'd5);

        // Back-pressure: out_ready low for six cycles while streaming 1..6.
        fork
            begin
                for (int i = 1; i <= 6; i++) send(80'(i), 7'd0, 32'(i), 1'b0);
            end
            begin
                repeat (2) @(posedge ap_clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge ap_clk);
                @(negedge ap_clk);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                @(posedge ap_clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check_cnt("cnt_bp", 16'd5);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(P40, 7'd0, 32'h7FFF_FFFF, 1'b1);
        send(80'sd5, 7'd0, 32'd5, 1'b0);
        ap_rst_n = 1'b0;
        sb.delete();
        @(negedge ap_clk);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_sat_count", 32'(sat_count), 32'd0);
        @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
        repeat (10) @(posedge ap_clk);
        #1;

        // Clear coincident with a saturating output handshake.
        out_ready = 1'b0;
        send(P40, 7'd0, 32'h7FFF_FFFF, 1'b1);
        @(posedge ap_clk);
        #1;
        clear_cnt = 1'b1;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        clear_cnt = 1'b0;
        check_cnt("clear_wins", 16'd0);

        // Counter saturation at 0xFFFF.
        for (int i = 0; i < 65535; i++) send(-P40, 7'd0, 32'h8000_0000, 1'b1);
        check_cnt("cnt_max", 16'hFFFF);
        send(P40, 7'd0, 32'h7FFF_FFFF, 1'b1);
        check_cnt("cnt_stick", 16'hFFFF);
        clear_cnt = 1'b1;
        @(posedge ap_clk);
        #1;
        clear_cnt = 1'b0;
        check_cnt("cnt_clear", 16'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
